// File: rtl/dsp48a1_mac_ctrl.sv
// dsp48a1_mac_ctrl
// Streams unsigned 18x18 operand pairs into a DSP48A1-style slice and
// collects the accumulated dot product from the slice P output.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The sender holds its payload stable while valid is high and
// ready is low. Ready never depends on valid on the same port.
//
// Ports
//   i_clk, i_rst_n            clock (rising edge), async active-low reset
//   i_in_valid / o_in_ready   operand pair handshake
//   i_in_a, i_in_b            unsigned operands
//   i_in_last                 final term of the current dot product
//   o_dsp_a, o_dsp_b          slice operands (0 unless a transfer happens)
//   o_dsp_c                   slice C operand (rounding constant or 0)
//   o_dsp_opmode              slice opmode, follows the tag at OPM_SKEW
//   i_dsp_p                   slice P output
//   o_out_valid / i_out_ready result handshake
//   o_out_data, o_out_count   result and number of accepted terms
//   o_dbg_state               current FSM state
//
// Parameters
//   P_LAT        cycles from operand on o_dsp_a/b to product on i_dsp_p
//   OPM_SKEW     cycles the opmode lags its operand (< P_LAT)
//   ROUND_SHIFT  result right-shift when rounding is enabled (1..47)
//
// Optional feature: define MACCTRL_ROUND_EN to add half an LSB via C on the
// first term and shift the captured result right by ROUND_SHIFT.
module dsp48a1_mac_ctrl #(
    parameter int P_LAT       = 3,
    parameter int OPM_SKEW    = 1,
    parameter int ROUND_SHIFT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [17:0] i_in_a,
    input  logic [17:0] i_in_b,
    input  logic        i_in_last,
    output logic [17:0] o_dsp_a,
    output logic [17:0] o_dsp_b,
    output logic [47:0] o_dsp_c,
    output logic [7:0]  o_dsp_opmode,
    input  logic [47:0] i_dsp_p,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [47:0] o_out_data,
    output logic [15:0] o_out_count,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } tag_t;

`ifdef MACCTRL_ROUND_EN
    localparam logic [7:0]  OPM_FIRST = 8'h0D;   // X=M, Z=C
    localparam logic [47:0] C_VALUE   = 48'd1 << (ROUND_SHIFT - 1);
`else
    localparam logic [7:0]  OPM_FIRST = 8'h01;   // X=M, Z=0
    localparam logic [47:0] C_VALUE   = 48'd0;
`endif
    localparam logic [7:0] OPM_ACC  = 8'h09;     // X=M, Z=P
    localparam logic [7:0] OPM_HOLD = 8'h08;     // X=0, Z=P

    state_t      r_state;
    logic        r_in_ready;
    tag_t        r_tag [1:P_LAT];
    logic        r_out_valid;
    logic [47:0] r_out_data;
    logic [15:0] r_count;
    logic [47:0] r_dsp_c;

    logic        w_in_xfer;
    logic        w_out_xfer;
    tag_t        w_tag_in;
    tag_t        w_tag_opm;
    logic        w_done;
    logic [47:0] w_p_capt;
    logic [7:0]  w_opmode;

    assign w_in_xfer  = i_in_valid & r_in_ready;
    assign w_out_xfer = r_out_valid & i_out_ready;

    // Tag entering the pipeline this cycle; all-zero when nothing transfers.
    assign w_tag_in.valid = w_in_xfer;
    assign w_tag_in.first = w_in_xfer & (r_state == S_IDLE);
    assign w_tag_in.last  = w_in_xfer & i_in_last;

    // The last term's product is on i_dsp_p when its tag reaches P_LAT.
    assign w_done = (r_state == S_DRAIN) & r_tag[P_LAT].valid & r_tag[P_LAT].last;

    generate
        if (OPM_SKEW == 0) begin : g_opm_now
            assign w_tag_opm = w_tag_in;
        end else begin : g_opm_tag
            assign w_tag_opm = r_tag[OPM_SKEW];
        end
    endgenerate

    always_comb begin
        w_opmode = OPM_HOLD;
        if (w_tag_opm.valid) begin
            w_opmode = w_tag_opm.first ? OPM_FIRST : OPM_ACC;
        end
    end

`ifdef MACCTRL_ROUND_EN
    assign w_p_capt = i_dsp_p >> ROUND_SHIFT;
`else
    assign w_p_capt = i_dsp_p;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_count     <= '0;
            r_dsp_c     <= '0;
            for (int k = 1; k <= P_LAT; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            r_dsp_c  <= C_VALUE;
            r_tag[1] <= w_tag_in;
            for (int k = 2; k <= P_LAT; k++) begin
                r_tag[k] <= r_tag[k-1];
            end

            if (w_in_xfer && (r_count != 16'hFFFF)) begin
                r_count <= r_count + 16'd1;
            end

            case (r_state)
                S_IDLE, S_ACCUM: begin
                    if (w_in_xfer && i_in_last) begin
                        r_state    <= S_DRAIN;
                        r_in_ready <= 1'b0;
                    end else begin
                        if (w_in_xfer) begin
                            r_state <= S_ACCUM;
                        end
                        r_in_ready <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    r_in_ready <= 1'b0;
                    if (w_done) begin
                        r_state     <= S_HOLD;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_p_capt;
                    end
                end
                S_HOLD: begin
                    if (w_out_xfer) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_count     <= '0;
                    end else begin
                        r_in_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    assign o_in_ready   = r_in_ready;
    assign o_dsp_a      = w_in_xfer ? i_in_a : 18'd0;
    assign o_dsp_b      = w_in_xfer ? i_in_b : 18'd0;
    assign o_dsp_c      = r_dsp_c;
    assign o_dsp_opmode = w_opmode;
    assign o_out_valid  = r_out_valid;
    assign o_out_data   = r_out_data;
    assign o_out_count  = r_count;
    assign o_dbg_state  = r_state;

endmodule

// File: doc/dsp48a1_mac_ctrl.md
DSP48A1_MAC_CTRL -- requirements
Module: dsp48a1_mac_ctrl

Interface
REQ-001 SHALL have parameter P_LAT, default 3: cycles from operand driven on DSP_A/DSP_B to the product appearing in DSP_P.
REQ-002 SHALL have parameter OPM_SKEW, default 1: cycles DSP_OPMODE lags its operand; must be < P_LAT.
REQ-003 SHALL have parameter ROUND_SHIFT, default 16: right-shift applied when MACCTRL_ROUND_EN is defined; range 1..47.
REQ-004 CLK  in  1  single clock, rising edge.
REQ-005 RST_N  in  1  reset; asynchronous and active-low.
REQ-006 IN_VALID  in  1  operand pair valid.
REQ-007 IN_READY  out  1  controller accepts operand pair.
REQ-008 IN_A, IN_B  in  18 each  unsigned operands.
REQ-009 IN_LAST  in  1  marks final term of a dot product.
REQ-010 DSP_A, DSP_B  out  18 each  operands to the slice.
REQ-011 DSP_C  out  48  post-adder Z operand.
REQ-012 DSP_OPMODE  out  8  slice opmode.
REQ-013 DSP_P  in  48  slice P output.
REQ-014 OUT_VALID  out  1  result valid.
REQ-015 OUT_READY  in  1  result consumer ready.
REQ-016 OUT_DATA  out  48  dot-product result.
REQ-017 OUT_COUNT  out  16  number of terms in the result.

Function
REQ-018 The transfer rules SHALL be as follows: transfer in when IN_VALID&IN_READY; transfer out when OUT_VALID&OUT_READY; one term per cycle, no bubbles required.
REQ-019 The FSM SHALL have states IDLE, ACCUM, DRAIN and HOLD.
REQ-020 The FSM SHALL make these transitions: IDLE->ACCUM on transfer with !IN_LAST; IDLE->DRAIN or ACCUM->DRAIN on transfer with IN_LAST; DRAIN->HOLD when the last term's tag reaches stage P_LAT; HOLD->IDLE on output transfer.
REQ-021 IN_READY SHALL be 1 only in IDLE or ACCUM; in IDLE and ACCUM it SHALL not depend on OUT_READY.
REQ-022 On transfer, DSP_A/DSP_B SHALL equal IN_A/IN_B in the same cycle; otherwise they SHALL be 0.
REQ-023 A tag pipeline of depth P_LAT SHALL carry {valid, first, last} per cycle; first = first term after IDLE.
REQ-024 DSP_OPMODE SHALL be driven from the tag at stage OPM_SKEW as follows: valid&first -> 8'h01 (X=M, Z=0); valid&!first -> 8'h09 (X=M, Z=P); not valid -> 8'h08 (X=0, Z=P, hold).
REQ-025 Bits 7:4 of DSP_OPMODE SHALL always be 0: add, no pre-adder, no carry.
REQ-026 In DRAIN, when the last-tag reaches stage P_LAT, the controller SHALL register DSP_P into OUT_DATA and set OUT_VALID the next cycle.
REQ-027 OUT_DATA, OUT_COUNT and OUT_VALID SHALL hold stable while OUT_VALID&!OUT_READY.
REQ-028 OUT_COUNT SHALL count accepted terms, saturate at 16'hFFFF, and clear on entering IDLE.
REQ-029 Arithmetic SHALL be unsigned; accumulation SHALL wrap modulo 2^48 with no overflow flag.
REQ-030 A single-term product (IN_LAST on the first transfer) SHALL be valid and yield OUT_COUNT=1.
REQ-031 IN_VALID low mid-ACCUM SHALL insert hold opmodes and SHALL leave the sum unchanged.

Reset
REQ-032 RST_N low SHALL asynchronously force state IDLE and clear the tag pipeline and OUT_COUNT.
REQ-033 RST_N low SHALL asynchronously force OUT_VALID=0, OUT_DATA=0, DSP_A=DSP_B=0, DSP_C=0 and DSP_OPMODE=8'h08.
REQ-034 IN_READY SHALL be 0 while RST_N is low and 1 from the first edge after release.
REQ-035 A reset mid-ACCUM or mid-DRAIN SHALL discard the partial sum, and no OUT_VALID SHALL follow.

Configuration
REQ-036 Macro MACCTRL_ROUND_EN SHALL control rounding.
REQ-037 With MACCTRL_ROUND_EN defined, the first-term opmode SHALL be 8'h0D (Z=C) and DSP_C SHALL be 1<<(ROUND_SHIFT-1).
REQ-038 With MACCTRL_ROUND_EN defined, OUT_DATA SHALL be {ROUND_SHIFT zeros, captured P[47:ROUND_SHIFT]}.
REQ-039 With MACCTRL_ROUND_EN undefined, the first-term opmode SHALL be 8'h01, DSP_C SHALL be 0 constant, and OUT_DATA SHALL be the captured P unmodified.

Verification
REQ-040 The bench SHALL apply back-to-back terms (2,3),(4,5),(6,7) with IN_LAST on the third and OUT_READY=1, and SHALL check OUT_DATA=68, OUT_COUNT=3, and OUT_VALID exactly P_LAT+1 cycles after the last transfer.
REQ-041 The bench SHALL apply the same terms with IN_VALID low for 2 cycles between terms, and SHALL check OUT_DATA=68 and opmode 8'h08 during the gaps.
REQ-042 The bench SHALL apply a single term (3FFFF,3FFFF) with IN_LAST, and SHALL check OUT_DATA=0xFFFF80001 and OUT_COUNT=1.
REQ-043 The bench SHALL hold OUT_READY=0 for 5 cycles in HOLD, and SHALL check that IN_READY=0, OUT_DATA is stable, and the second product starts only after the output transfer.
REQ-044 The bench SHALL pulse RST_N low mid-ACCUM after 2 terms, and SHALL check for no OUT_VALID and that the next product (1,1) alone yields OUT_DATA=1.
REQ-045 With MACCTRL_ROUND_EN defined and ROUND_SHIFT=16, the bench SHALL apply the single term (0x18000,1), and SHALL check OUT_DATA=2 and DSP_OPMODE=8'h0D on the first term.
